// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_pkg
// Description : Shared CPU definitions used by the fetch sequencer and the
//               instruction decoder: one-hot phase encodings, opcode values
//               and a helper that classifies opcodes by execute length.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

  // One-hot phase encodings driven to the decoder; all-zero means idle.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0000,
    ST_FETCH = 4'b0001,
    ST_EXEC1 = 4'b0010,
    ST_EXEC2 = 4'b0100,
    ST_EXEC3 = 4'b1000
  } state_e;

  // Opcode field values (instr_word[7:4]).
  localparam logic [3:0] c_op_sta = 4'b0000;
  localparam logic [3:0] c_op_jmp = 4'b0001;
  localparam logic [3:0] c_op_stp = 4'b0010;
  localparam logic [3:0] c_op_lda = 4'b0011;
  localparam logic [3:0] c_op_mul = 4'b1101;
  localparam logic [3:0] c_op_ldr = 4'b1110;

  // True for opcodes that need more than one execute phase.
  function automatic logic is_multi_exec(input logic [3:0] op);
    return (op == c_op_lda) || (op == c_op_ldr) || (op == c_op_mul);
  endfunction

endpackage : fetch_sequencer_pkg
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction fetch/execute phase sequencer. Steps through
//               FETCH and one to three EXEC phases per instruction, latches
//               the instruction word, and counts retired instructions.
// Ports       : clk           - system clock (rising edge)
//               reset         - asynchronous active-high reset
//               run           - start request, honoured only while idle
//               instr_word    - program memory data at current PC
//               state         - one-hot phase (0000 = idle)
//               inst          - latched opcode
//               operand       - latched operand field
//               halted        - high while idle
//               retire        - pulse in the last exec phase
//               retired_count - retired instruction counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [7:0]         instr_word,
  output logic [3:0]         state,
  output logic [3:0]         inst,
  output logic [3:0]         operand,
  output logic               halted,
  output logic               retire,
  output logic [COUNT_W-1:0] retired_count
);

  // Held as a plain vector so that any corrupted non-one-hot value is
  // representable and can be steered back to idle.
  logic [3:0]         state_q;
  logic [3:0]         state_d;
  logic [3:0]         inst_q;
  logic [3:0]         operand_q;
  logic [COUNT_W-1:0] count_q;
  logic               retire_w;

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:  state_d = run ? ST_FETCH : ST_IDLE;
      ST_FETCH: state_d = ST_EXEC1;
      ST_EXEC1: begin
        if (inst_q == c_op_stp)          state_d = ST_IDLE;
        else if (is_multi_exec(inst_q))  state_d = ST_EXEC2;
        else                             state_d = ST_FETCH;
      end
      ST_EXEC2: state_d = (inst_q == c_op_mul) ? ST_EXEC3 : ST_FETCH;
      ST_EXEC3: state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Retire marks whichever exec phase is the last one for the held opcode.
  assign retire_w = ((state_q == ST_EXEC1) && !is_multi_exec(inst_q)) ||
                    ((state_q == ST_EXEC2) && (inst_q != c_op_mul))   ||
                     (state_q == ST_EXEC3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      inst_q    <= 4'b0000;
      operand_q <= 4'b0000;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      // The instruction register only captures on the FETCH->EXEC1 edge.
      if (state_q == ST_FETCH) begin
        inst_q    <= instr_word[7:4];
        operand_q <= instr_word[3:0];
      end
      if (retire_w) begin
        count_q <= count_q + COUNT_W'(1);
      end
    end
  end

  assign state         = state_q;
  assign inst          = inst_q;
  assign operand       = operand_q;
  assign halted        = (state_q == ST_IDLE);
  assign retire        = retire_w;
  assign retired_count = count_q;

endmodule : fetch_sequencer
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Scoreboard testbench for fetch_sequencer. A cycle model
//               predicts the outputs after each clock edge; predictions are
//               queued as inputs are driven and compared on the falling edge.
//               A second instance with a 4-bit counter checks wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic [7:0]  instr_word;

  logic [3:0]  state_o, inst_o, operand_o;
  logic        halted_o, retire_o;
  logic [15:0] cnt_o;

  logic [3:0]  state_s, inst_s, operand_s;
  logic        halted_s, retire_s;
  logic [3:0]  cnt_s;

  fetch_sequencer u_dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .instr_word    (instr_word),
    .state         (state_o),
    .inst          (inst_o),
    .operand       (operand_o),
    .halted        (halted_o),
    .retire        (retire_o),
    .retired_count (cnt_o)
  );

  fetch_sequencer #(.COUNT_W(4)) u_dut_w4 (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .instr_word    (instr_word),
    .state         (state_s),
    .inst          (inst_s),
    .operand       (operand_s),
    .halted        (halted_s),
    .retire        (retire_s),
    .retired_count (cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    logic [3:0] st;
    logic       ret;
    logic       hlt;
    logic [3:0] inst;
    logic [3:0] opnd;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // m_phase: 0 idle, 1 fetch, k>=2 is exec phase k-1
  int         m_phase;
  logic [3:0] m_inst;
  logic [3:0] m_opnd;
  int         m_count;

  // Number of exec phases per opcode, from the latency table.
  function automatic int nexec(input logic [3:0] op);
    case (op)
      4'h3, 4'hE: return 2;
      4'hD:       return 3;
      default:    return 1;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.st   = (m_phase == 0) ? 4'b0000 : 4'(1 << (m_phase - 1));
    e.ret  = (m_phase >= 2) && ((m_phase - 1) == nexec(m_inst));
    e.hlt  = (m_phase == 0);
    e.inst = m_inst;
    e.opnd = m_opnd;
    e.cnt  = m_count;
    return e;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_inst  = 4'h0;
    m_opnd  = 4'h0;
    m_count = 0;
  endtask

  task automatic model_step(input logic r, input logic [7:0] w);
    if (m_phase == 0) begin
      m_phase = r ? 1 : 0;
    end else if (m_phase == 1) begin
      m_inst  = w[7:4];
      m_opnd  = w[3:0];
      m_phase = 2;
    end else if ((m_phase - 1) == nexec(m_inst)) begin
      m_count++;
      m_phase = (m_inst == 4'h2) ? 0 : 1;
    end else begin
      m_phase++;
    end
  endtask

  // Drive inputs for the next rising edge and queue the predicted outputs.
  task automatic tick(input logic r, input logic [7:0] w);
    @(negedge clk);
    #1;
    run        = r;
    instr_word = w;
    model_step(r, w);
    exp_q.push_back(model_out());
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("state",   32'(state_o),   32'(mon_e.st));
      chk("retire",  32'(retire_o),  32'(mon_e.ret));
      chk("halted",  32'(halted_o),  32'(mon_e.hlt));
      chk("inst",    32'(inst_o),    32'(mon_e.inst));
      chk("operand", 32'(operand_o), 32'(mon_e.opnd));
      chk("count",   32'(cnt_o),     32'(mon_e.cnt & 16'hFFFF));
      chk("count_w4", 32'(cnt_s),    32'(mon_e.cnt & 4'hF));
      chk("state_w4", 32'(state_s),  32'(mon_e.st));
      if (mon_e.cnt == 17) chk("count_w4_wrap17", 32'(cnt_s), 32'd1);
    end
  end

  // Program runner: instruction words are presented only during FETCH;
  // all other cycles carry random garbage on instr_word and, unless run is
  // held, random run values that must be ignored.
  logic [7:0] prog_q[$];

  task automatic run_prog(input bit hold);
    int         idx;
    int         guard;
    logic [7:0] w;
    logic       r;
    idx   = 0;
    guard = 0;
    if (m_phase == 0) tick(1'b1, 8'($urandom));
    while (m_phase != 0 && guard < 200) begin
      w = 8'($urandom);
      r = hold ? 1'b1 : 1'($urandom_range(0, 1));
      if (m_phase == 1) begin
        w = (idx < prog_q.size()) ? prog_q[idx] : 8'h20;
        idx++;
      end
      tick(r, w);
      guard++;
    end
    if (guard >= 200) chk("prog_timeout", 32'(guard), 32'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset      = 1'b1;
    run        = 1'b0;
    instr_word = 8'h00;
    model_reset();
    #1;
    chk("rst_state",  32'(state_o),  32'd0);
    chk("rst_halted", 32'(halted_o), 32'd1);
    chk("rst_retire", 32'(retire_o), 32'd0);
    chk("rst_count",  32'(cnt_o),    32'd0);

    @(negedge clk);
    #1 reset = 1'b0;
    repeat (2) tick(1'b0, 8'($urandom));

    // LDA 5 then stop
    prog_q = '{8'h35};
    run_prog(1'b0);
    repeat (2) tick(1'b0, 8'($urandom));

    // MUL
    prog_q = '{8'hD2};
    run_prog(1'b0);
    tick(1'b0, 8'($urandom));

    // JMP, STA, STP with run held high: restart only after an idle cycle
    prog_q = '{8'h1A, 8'h03, 8'h20};
    run_prog(1'b1);
    prog_q = '{8'h9F};
    run_prog(1'b0);
    tick(1'b0, 8'($urandom));

    // Mixed program including every exec length and undefined opcodes
    prog_q = '{8'hE7, 8'h35, 8'hD2, 8'h80, 8'hC1, 8'h1A, 8'hDF, 8'h03, 8'hB4};
    run_prog(1'b0);
    tick(1'b0, 8'($urandom));

    // Asynchronous reset during EXEC2 of LDR
    tick(1'b1, 8'($urandom));   // -> FETCH
    tick(1'b0, 8'hE7);          // -> EXEC1
    tick(1'b0, 8'($urandom));   // -> EXEC2
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_state",  32'(state_o),  32'd0);
    chk("arst_inst",   32'(inst_o),   32'd0);
    chk("arst_opnd",   32'(operand_o), 32'd0);
    chk("arst_count",  32'(cnt_o),    32'd0);
    chk("arst_retire", 32'(retire_o), 32'd0);
    chk("arst_halted", 32'(halted_o), 32'd1);
    exp_q.delete();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (3) tick(1'b0, 8'($urandom));

    // 17 NOPs exercise the 4-bit counter wrap
    prog_q.delete();
    repeat (17) prog_q.push_back(8'h80);
    run_prog(1'b0);
    tick(1'b0, 8'($urandom));

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("final_count_w4", 32'(cnt_s), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_fetch_sequencer
`default_nettype wire
